wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage that owns the single register-file write port (RegWrite/WriteRegister/WriteData).
//  Merges in-order pipeline results with out-of-order long-latency (mul/div/load-miss) results.
//  Pipeline results take priority; late results are buffered in a small FIFO until the port is free.
//  A starvation counter raises a stall request so that buffered results cannot be held off forever.
// PARAMETERS
//  DEPTH       4   late-result FIFO entries; power of 2, >=2
//  MAX_STARVE  3   consecutive cycles in which the pipeline beats a non-empty FIFO before stall_req is asserted
// PORTS
//  clk            in   1    clock; all state updates on posedge
//  rst            in   1    synchronous, active-high reset
//  pipe_valid     in   1    pipeline result present this cycle (MEM/WB)
//  pipe_rd        in   5    pipeline destination register
//  pipe_data      in   32   pipeline result
//  lu_valid       in   1    long-latency result offered
//  lu_ready       out  1    long-latency result accepted when lu_valid&&lu_ready
//  lu_rd          in   5    long-latency destination register
//  lu_data        in   32   long-latency result
//  stall_req      out  1    request that upstream freeze and hold pipe_valid=0
//  fifo_count     out  $clog2(DEPTH+1)  FIFO occupancy
//  RegWrite       out  1    register-file write enable (registered)
//  WriteRegister  out  5    register-file write address (registered)
//  WriteData      out  32   register-file write data (registered)
// BEHAVIOUR
//  - Reset: RegWrite=0, WriteRegister=0, WriteData=0, FIFO empty, fifo_count=0, starve_cnt=0, stall_req=0.
//    lu_ready=0 while rst is high. Reset mid-operation discards all FIFO contents.
//  - Arbitration in cycle t:
//    - If pipe_valid && pipe_rd!=0, the pipeline wins.
//    - Otherwise, if the FIFO is non-empty, the head is popped.
//    - Otherwise, no write.
//    - pipe_valid with pipe_rd==0 is consumed, produces no write and leaves the port free.
//  - The winner is registered at posedge end of t, so RegWrite etc. are valid during t+1 and the register
//    file commits at posedge end of t+1. Pipeline latency = 1 cycle. No write => RegWrite=0 next cycle.
//    WriteRegister/WriteData hold their last values.
//  - lu_ready = !rst && (count < DEPTH), derived from registered count only (no same-cycle pop credit).
//  - Accepted late results with lu_rd==0 are dropped (not enqueued).
//  - No enqueue-to-output passthrough: a late result accepted into an empty FIFO is written no earlier than t+2.
//  - Simultaneous enqueue and pop: count is unchanged; read and write pointers both advance.
//    Pointers wrap mod DEPTH. FIFO order is strictly preserved.
//  - starve_cnt:
//    - Increments when FIFO non-empty && pipeline wins.
//    - Clears on any pop or when the FIFO is empty.
//    - Saturates at MAX_STARVE.
//  - stall_req = (starve_cnt==MAX_STARVE), combinational from the register.
//    Upstream must drive pipe_valid=0 in the same cycle. The head then pops, the counter clears, and
//    stall_req drops the next cycle.
//  - Assertion: stall_req && pipe_valid never true.
//  - WAW ordering between pipe and late results to the same rd is the hazard unit's responsibility,
//    not this block's.
// CONFIGURATION
//  - WB_BYPASS_EN defined: the register file reads before write, so this option adds forward ports
//    byp_rs1/byp_rs2 (in, 5) and byp_hit1/byp_hit2 (out, 1), byp_data1/byp_data2 (out, 32).
//    - byp_hitN = RegWrite && WriteRegister==byp_rsN && byp_rsN!=0.
//    - byp_dataN = hit ? WriteData : 32'b0. Purely combinational.
//  - WB_BYPASS_EN undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package riscv_pkg:
//    - XLEN=32, REG_ADDR_W=5.
//    - typedef wb_req_t {logic [REG_ADDR_W-1:0] rd; logic [XLEN-1:0] data;}.
//  - One sub-module, wb_fifo: synchronous FIFO of wb_req_t with push/pop/count/full/empty and sync reset.
//  - Arbitration, starvation counter and output registers live in wb_arbiter.
// TESTING
//  1. rst high 2 cycles with lu_valid=1 -> lu_ready=0, RegWrite=0, fifo_count=0. After release, lu_ready=1.
//  2. pipe_valid, rd=5, data=32'hDEADBEEF at t -> RegWrite=1, WriteRegister=5, WriteData=32'hDEADBEEF
//     at t+1. Same stimulus with rd=0 -> RegWrite=0.
//  3. DEPTH=4, pipe valid every cycle, 5 late results offered -> 4 accepted, fifo_count=4, lu_ready=0,
//     5th held until a pop.
//  4. MAX_STARVE=3, FIFO holds {rd3:1, rd4:2}, pipe valid every cycle -> stall_req=1 after 3 pipe wins.
//     With pipe_valid=0, rd3=1 then rd4=2 written in order.
//  5. count=3, simultaneous enqueue (rd9:0x55) and pop -> count stays 3; entry 0x55 exits after the
//     older entries, across pointer wrap.
//  6. WB_BYPASS_EN: RegWrite with rd7=0x1234, byp_rs1=7, byp_rs2=0 -> byp_hit1=1, byp_data1=0x1234,
//     byp_hit2=0, byp_data2=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared datapath widths and the writeback request type used by the
//           writeback arbiter and its late-result FIFO.
// Contents: XLEN, REG_ADDR_W, wb_req_t, is_x0() helper.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Writes to x0 are architecturally discarded.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
    return (rd == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Purpose : Synchronous FIFO of wb_req_t holding long-latency results until
//           the register-file write port is free. No read-through: an entry
//           pushed in cycle t is visible at the head from cycle t+1.
// Ports   : clk, rst (sync, active-high)
//           push_i/push_data_i  enqueue (ignored when full)
//           pop_i               dequeue (ignored when empty)
//           head_o              oldest entry
//           count_o             occupancy, full_o / empty_o flags
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  wb_req_t                    push_data_i,
  input  logic                       pop_i,
  output wb_req_t                    head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  wb_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            w_push;
  logic            w_pop;

  assign full_o  = (count_q == C_FULL);
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Purpose : Writeback stage owning the single register-file write port.
//           In-order pipeline results win; long-latency results wait in a
//           FIFO. A starvation counter raises stall_req so buffered results
//           always drain eventually.
// Ports   : clk, rst (sync, active-high)
//           pipe_valid/pipe_rd/pipe_data   pipeline result
//           lu_valid/lu_ready/lu_rd/lu_data long-latency result handshake
//           stall_req                       freeze upstream (pipe_valid must be 0)
//           fifo_count                      FIFO occupancy
//           RegWrite/WriteRegister/WriteData registered write port
//           byp_rs1/2, byp_hit1/2, byp_data1/2 (only with WB_BYPASS_EN)
// Config  : `define WB_BYPASS_EN adds the combinational writeback forward ports.
// Revision: 1.0 - initial release
// ============================================================================
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_valid,
  input  logic [REG_ADDR_W-1:0]      pipe_rd,
  input  logic [XLEN-1:0]            pipe_data,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [REG_ADDR_W-1:0]      lu_rd,
  input  logic [XLEN-1:0]            lu_data,
  output logic                       stall_req,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       RegWrite,
  output logic [REG_ADDR_W-1:0]      WriteRegister,
  output logic [XLEN-1:0]            WriteData
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0]      byp_rs1,
  input  logic [REG_ADDR_W-1:0]      byp_rs2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [XLEN-1:0]            byp_data1,
  output logic [XLEN-1:0]            byp_data2
`endif
);

  localparam int SW = $clog2(MAX_STARVE+1);
  localparam logic [SW-1:0] C_MAX_STARVE = SW'(MAX_STARVE);

  // FIFO interface
  wb_req_t                    w_fifo_head;
  wb_req_t                    w_fifo_in;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic                       w_fifo_push;
  logic                       w_fifo_pop;
  logic                       w_pipe_win;

  // State
  logic                       regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0]      wreg_q,     wreg_d;
  logic [XLEN-1:0]            wdata_q,    wdata_d;
  logic [SW-1:0]              starve_q,   starve_d;

  // Readiness comes from the registered count only; a pop in the same cycle
  // does not free a slot until the next cycle.
  assign lu_ready    = !rst && !w_fifo_full;
  assign w_fifo_push = lu_valid && lu_ready && !is_x0(lu_rd);
  assign w_fifo_in   = '{rd: lu_rd, data: lu_data};

  wb_fifo #(
    .DEPTH       (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_fifo_push),
    .push_data_i (w_fifo_in),
    .pop_i       (w_fifo_pop),
    .head_o      (w_fifo_head),
    .count_o     (fifo_count),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty)
  );

  always_comb begin
    // A pipeline result to x0 is consumed but leaves the port free.
    w_pipe_win = pipe_valid && !is_x0(pipe_rd);
    w_fifo_pop = !w_pipe_win && !w_fifo_empty;
    regwrite_d = w_pipe_win || w_fifo_pop;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (w_pipe_win) begin
      wreg_d  = pipe_rd;
      wdata_d = pipe_data;
    end else if (w_fifo_pop) begin
      wreg_d  = w_fifo_head.rd;
      wdata_d = w_fifo_head.data;
    end

    // Count consecutive cycles the pipeline beats a waiting FIFO head.
    // Any other cycle is either a pop or an empty FIFO, both of which clear it.
    starve_d = '0;
    if (w_pipe_win && !w_fifo_empty) begin
      starve_d = (starve_q == C_MAX_STARVE) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
    end
  end

  assign stall_req     = (starve_q == C_MAX_STARVE);
  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;

`ifdef WB_BYPASS_EN
  // Register file reads before it writes, so forward the in-flight write.
  assign byp_hit1  = regwrite_q && (wreg_q == byp_rs1) && !is_x0(byp_rs1);
  assign byp_hit2  = regwrite_q && (wreg_q == byp_rs2) && !is_x0(byp_rs2);
  assign byp_data1 = byp_hit1 ? wdata_q : '0;
  assign byp_data2 = byp_hit2 ? wdata_q : '0;
`endif

`ifndef SYNTHESIS
  // Upstream must honour stall_req in the same cycle.
  a_no_pipe_during_stall: assert property (
    @(posedge clk) disable iff (rst) !(stall_req && pipe_valid));
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter
// Purpose : Scoreboard bench for wb_arbiter. A driver issues directed and
//           random stimulus, steps a queue-based reference model and pushes
//           the expected register-file writes; a monitor pops and compares
//           whenever RegWrite is seen.
// Config  : `define WB_BYPASS_EN to also exercise the forward ports.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
  import riscv_pkg::*;

  localparam int DEPTH      = 4;
  localparam int MAX_STARVE = 3;
  localparam int CW         = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  pipe_valid = 1'b0;
  logic [REG_ADDR_W-1:0] pipe_rd = '0;
  logic [XLEN-1:0]       pipe_data = '0;
  logic                  lu_valid = 1'b0;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_rd = '0;
  logic [XLEN-1:0]       lu_data = '0;
  logic                  stall_req;
  logic [CW-1:0]         fifo_count;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteRegister;
  logic [XLEN-1:0]       WriteData;
`ifdef WB_BYPASS_EN
  logic [REG_ADDR_W-1:0] byp_rs1 = '0;
  logic [REG_ADDR_W-1:0] byp_rs2 = '0;
  logic                  byp_hit1, byp_hit2;
  logic [XLEN-1:0]       byp_data1, byp_data2;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH         (DEPTH),
    .MAX_STARVE    (MAX_STARVE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_valid    (pipe_valid),
    .pipe_rd       (pipe_rd),
    .pipe_data     (pipe_data),
    .lu_valid      (lu_valid),
    .lu_ready      (lu_ready),
    .lu_rd         (lu_rd),
    .lu_data       (lu_data),
    .stall_req     (stall_req),
    .fifo_count    (fifo_count),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData)
`ifdef WB_BYPASS_EN
    ,
    .byp_rs1       (byp_rs1),
    .byp_rs2       (byp_rs2),
    .byp_hit1      (byp_hit1),
    .byp_hit2      (byp_hit2),
    .byp_data1     (byp_data1),
    .byp_data2     (byp_data2)
`endif
  );

  // Reference model state
  typedef struct { logic [4:0] rd; logic [31:0] data; } lr_t;
  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } exp_t;
  lr_t  lq[$];          // buffered late results, oldest first
  exp_t sb[$];          // expected writes, tagged with the deciding cycle
  int   m_starve = 0;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;
  bit mon_en = 1'b0;
  bit acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the matching model update.
  task automatic step(input bit r, input bit pv_in, input logic [4:0] prd, input logic [31:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld, output bit accepted);
    bit  pv, ready, win;
    lr_t h;
    @(negedge clk);
    pv = pv_in && (m_starve != MAX_STARVE);   // upstream obeys stall
    rst = r; pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    #1;
    ready = !r && (lq.size() < DEPTH);
    chk("lu_ready", 32'(lu_ready), 32'(ready));
    chk("fifo_count", 32'(fifo_count), 32'(lq.size()));
    chk("stall_req", 32'(stall_req), 32'(m_starve == MAX_STARVE));
    accepted = lv && ready;
    if (r) begin
      lq.delete();
      m_starve = 0;
      return;
    end
    win = pv && (prd != 5'd0);
    if (win) begin
      sb.push_back('{cyc, prd, pd});
      m_starve = (lq.size() != 0) ? ((m_starve < MAX_STARVE) ? m_starve + 1 : MAX_STARVE) : 0;
    end else begin
      if (lq.size() != 0) begin
        h = lq.pop_front();
        sb.push_back('{cyc, h.rd, h.data});
      end
      m_starve = 0;
    end
    if (accepted && (lrd != 5'd0)) lq.push_back('{lrd, ld});
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a);
  endtask

  // Offer one late result (held until accepted) while the pipeline is busy.
  task automatic offer_busy(input logic [4:0] lrd, input logic [31:0] ld);
    bit a;
    int tries;
    tries = 0;
    a = 0;
    while (!a && tries < 20) begin
      step(0, 1, 5'($urandom_range(1, 31)), $urandom, 1, lrd, ld, a);
      tries++;
    end
    n_cmp++;
    if (!a) begin
      n_err++;
      $display("FAIL accept_timeout: rd %0d not accepted after %0d cycles", lrd, tries);
    end
  endtask

  // Monitor: every RegWrite must match the oldest expected write, one cycle late.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
          e = sb.pop_front();
          n_cmp++; n_err++;
          $display("FAIL write_missing: RegWrite 0 expected rd %0d data 0x%0h (cycle %0d)", e.rd, e.data, cyc);
        end
        if (RegWrite) begin
          if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
            e = sb.pop_front();
            chk("WriteRegister", 32'(WriteRegister), 32'(e.rd));
            chk("WriteData", WriteData, e.data);
          end else begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_write: got rd %0d data 0x%0h expected no write (cycle %0d)",
                     WriteRegister, WriteData, cyc);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a late result offered: nothing accepted.
    step(1, 0, 0, 0, 1, 5'd1, 32'h11, acc);
    step(1, 0, 0, 0, 1, 5'd1, 32'h11, acc);
    @(posedge clk); #1;
    chk("reset_RegWrite", 32'(RegWrite), 32'd0);
    chk("reset_WriteRegister", 32'(WriteRegister), 32'd0);
    chk("reset_WriteData", WriteData, 32'd0);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);
    mon_en = 1'b1;

    // Pipeline write, then a pipeline result to x0.
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, acc);
    step(0, 1, 5'd0, 32'h12345678, 0, 0, 0, acc);
    idle(2);

    // Five late results against a busy pipeline: FIFO fills, fifth waits.
    for (int i = 0; i < 5; i++) offer_busy(5'(20 + i), 32'(100 + i));
    idle(8);

    // Starvation: two buffered results, pipeline keeps winning until stall.
    offer_busy(5'd3, 32'd1);
    offer_busy(5'd4, 32'd2);
    for (int i = 0; i < 4; i++) step(0, 1, 5'(8 + i), 32'(200 + i), 0, 0, 0, acc);
    idle(4);

    // Count 3, then simultaneous enqueue and pop (pointers wrap here).
    offer_busy(5'd10, 32'hA0);
    offer_busy(5'd11, 32'hA1);
    offer_busy(5'd12, 32'hA2);
    step(0, 0, 0, 0, 1, 5'd9, 32'h55, acc);
    idle(6);

    // Late result to x0 is accepted and dropped.
    step(0, 0, 0, 0, 1, 5'd0, 32'hBAD0, acc);
    idle(2);

    // Reset mid-operation discards buffered results.
    offer_busy(5'd13, 32'hB0);
    offer_busy(5'd14, 32'hB1);
    offer_busy(5'd15, 32'hB2);
    step(1, 1, 5'd16, 32'hB3, 1, 5'd17, 32'hB4, acc);
    idle(4);

`ifdef WB_BYPASS_EN
    step(0, 1, 5'd7, 32'h1234, 0, 0, 0, acc);
    @(posedge clk); #1;
    byp_rs1 = 5'd7; byp_rs2 = 5'd0;
    #1;
    chk("byp_hit1", 32'(byp_hit1), 32'd1);
    chk("byp_data1", byp_data1, 32'h1234);
    chk("byp_hit2", 32'(byp_hit2), 32'd0);
    chk("byp_data2", byp_data2, 32'd0);
    byp_rs1 = '0;
    idle(2);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom, acc);
    end
    idle(8);

    @(negedge clk); #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
